store_buffer: RTL
=================

Name: store_buffer

Overview:
- FIFO of committed stores that sits directly downstream of the ROB commit port.
- Accepts a store in the cycle the ROB retires it, then drains entries in order to data memory over a request/grant handshake.
- Gives the MEM stage a combinational store-to-load forwarding and conflict lookup, so loads never read stale memory while younger committed stores are still buffered.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of count_o.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, synchronous, active-low
- commit_valid_i  in  1  ROB commit valid this cycle
- commit_store_i  in  1  committing instruction is a store
- commit_addr_i  in  32  store byte address
- commit_data_i  in  32  store data, right-aligned
- commit_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved
- full_o  out  1  count == DEPTH; the ROB must not commit a store while this is high
- empty_o  out  1  count == 0
- count_o  out  CNT_W  occupied entries
- mem_req_o  out  1  head entry valid
- mem_addr_o  out  32  head word address, low two bits zero
- mem_data_o  out  32  head data, lane-aligned
- mem_be_o  out  4  head byte enables
- mem_gnt_i  in  1  memory accepts the head this cycle
- ld_valid_i  in  1  load lookup valid
- ld_addr_i  in  32  load byte address
- ld_size_i  in  2  load size, same encoding as commit_size_i
- ld_hit_o  out  1  load fully forwarded from the buffer
- ld_data_o  out  32  forwarded word, lane-aligned
- ld_conflict_o  out  1  load overlaps buffered bytes but cannot be fully forwarded; MEM must stall
- err_o  out  1  sticky error flag (overflow, misaligned or reserved size)

Behaviour:
- Reset: all state updates on posedge clk_i when rstn_i == 0. Pointers = 0, count = 0, entries invalid, err_o = 0. Resulting outputs: empty_o = 1, full_o = 0, count_o = 0, mem_req_o = 0, ld_hit_o = 0, ld_conflict_o = 0, mem_addr_o/mem_data_o/mem_be_o/ld_data_o = 0. Reset during a pending request drops every entry; no grant is expected afterwards.
- Push condition: commit_valid_i & commit_store_i & ~full_o & aligned & size != 3.
- Alignment: a half is aligned when addr[0] == 0; a word is aligned when addr[1:0] == 0.
- Lane formatting at push:
  - byte: be = 1 << addr[1:0]; data = {4{data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; data = {2{data[15:0]}}.
  - word: be = 4'b1111; data unchanged.
  - The stored address is {addr[31:2], 2'b00}.
- Dropped stores:
  - A push attempt while full, a misaligned store or size == 3 is dropped, sets err_o (sticky until reset) and leaves state unchanged.
  - Non-store commits are ignored.
- Push latency: a store pushed at edge N appears at the head (if the buffer was empty) with mem_req_o = 1 during cycle N+1. There is no bypass from the commit port to the memory port.
- Memory handshake:
  - mem_req_o = ~empty.
  - Head address, data and byte enables hold stable until mem_gnt_i.
  - The head pops at the edge where mem_req_o & mem_gnt_i; mem_gnt_i while empty is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. full_o is evaluated from pre-edge count, so a push while full is dropped even when a pop occurs in the same cycle.
- Pointer wrap: modulo DEPTH. full and empty are derived from count, not from pointer equality.
- Forwarding, combinational on registered contents only (a same-cycle push is not visible):
  - Load byte enables are formed exactly as for a store.
  - Matching entries are those with the same word address (addr[31:2]).
  - If the youngest matching entry's be covers all load bytes: ld_hit_o = 1 and ld_data_o = that entry's data.
  - Else, if any matching entry overlaps the load bytes: ld_conflict_o = 1.
  - Otherwise both are 0.
  - All forwarding outputs are 0 when ld_valid_i = 0.
  - A misaligned load forces ld_conflict_o = 1 when any match exists.
  - An entry being granted this cycle still participates in the lookup.

Test Plan:
- Reset, then push a word store of 0xDEADBEEF at 0x100 with mem_gnt_i = 0 → next cycle mem_req_o = 1, mem_addr_o = 0x100, mem_be_o = 4'hF, count_o = 1; holds stable until mem_gnt_i = 1, then empty_o = 1 the cycle after.
- Push byte 0xAB at 0x203 → mem_be_o = 4'b1000, mem_data_o = 0xABABABAB, mem_addr_o = 0x200.
- Push 4 stores with no grant → full_o = 1, count_o = 4. A fifth push is dropped and err_o = 1. Then grant four times → drain in push order with wrap-around verified, empty_o = 1.
- Full buffer, simultaneous push and grant → push dropped and err_o set. With count 3, simultaneous push and grant → count stays 3 and order is preserved.
- Buffer holds word 0x11223344 at 0x40 (older) and half 0xBEEF at 0x42 (younger):
  - byte load at 0x43 → ld_hit_o = 1, ld_data_o = 0xBEEFBEEF.
  - word load at 0x40 → ld_conflict_o = 1, ld_hit_o = 0.
  - load at 0x80 → both 0.
- Push half at 0x101 → dropped, err_o = 1, count_o = 0. Assert rstn_i = 0 mid-drain with 2 entries → next cycle count_o = 0, mem_req_o = 0, err_o = 0.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if: commit, memory-drain and load-lookup signals of the store buffer
//   commit_*  : ROB commit port (valid, store flag, byte address, data, size)
//   full/empty/count : occupancy status
//   mem_*     : head entry request/grant towards data memory
//   ld_*      : MEM-stage forwarding lookup and its hit/data/conflict result
//   err_o     : sticky error flag
//   modport slave is the buffer, modport master is its environment
interface store_buffer_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic             commit_valid_i;
   logic             commit_store_i;
   logic [31:0]      commit_addr_i;
   logic [31:0]      commit_data_i;
   logic [1:0]       commit_size_i;
   logic             full_o;
   logic             empty_o;
   logic [CNT_W-1:0] count_o;
   logic             mem_req_o;
   logic [31:0]      mem_addr_o;
   logic [31:0]      mem_data_o;
   logic [3:0]       mem_be_o;
   logic             mem_gnt_i;
   logic             ld_valid_i;
   logic [31:0]      ld_addr_i;
   logic [1:0]       ld_size_i;
   logic             ld_hit_o;
   logic [31:0]      ld_data_o;
   logic             ld_conflict_o;
   logic             err_o;
   modport slave (
      input  commit_valid_i, commit_store_i, commit_addr_i, commit_data_i, commit_size_i,
      input  mem_gnt_i, ld_valid_i, ld_addr_i, ld_size_i,
      output full_o, empty_o, count_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
      output ld_hit_o, ld_data_o, ld_conflict_o, err_o
   );
   modport master (
      output commit_valid_i, commit_store_i, commit_addr_i, commit_data_i, commit_size_i,
      output mem_gnt_i, ld_valid_i, ld_addr_i, ld_size_i,
      input  full_o, empty_o, count_o, mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
      input  ld_hit_o, ld_data_o, ld_conflict_o, err_o
   );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores with memory drain and load forwarding
//   clk_i  : clock
//   rstn_i : synchronous active-low reset
//   sb     : store_buffer_if.slave (commit port, memory request/grant, load lookup, status)
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input logic           clk_i,
   input logic           rstn_i,
   store_buffer_if.slave sb
);
   localparam int PTR_W = $clog2(DEPTH);
   function automatic logic [3:0] be_of(input logic [1:0] a, input logic [1:0] sz);
      return sz == 2'd0 ? 4'b0001 << a : sz == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction
   function automatic logic [31:0] lane(input logic [1:0] sz, input logic [31:0] d);
      return sz == 2'd0 ? {4{d[7:0]}} : sz == 2'd1 ? {2{d[15:0]}} : d;
   endfunction
   function automatic logic bad(input logic [1:0] a, input logic [1:0] sz);
      return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
   endfunction
   logic [29:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [3:0]       be_q   [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [PTR_W-1:0] head_q, tail_q, idx, yng;
   logic [CNT_W-1:0] count_q;
   logic             err_q, attempt, push, pop, full, empty, found, overlap, ld_bad, hit;
   logic [3:0]       ld_be;
   assign full    = count_q == CNT_W'(DEPTH);
   assign empty   = count_q == '0;
   assign attempt = sb.commit_valid_i & sb.commit_store_i;
   assign push    = attempt & ~full & ~bad(sb.commit_addr_i[1:0], sb.commit_size_i);
   assign pop     = ~empty & sb.mem_gnt_i;
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) begin
            addr_q[tail_q]  <= sb.commit_addr_i[31:2];
            data_q[tail_q]  <= lane(sb.commit_size_i, sb.commit_data_i);
            be_q[tail_q]    <= be_of(sb.commit_addr_i[1:0], sb.commit_size_i);
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (attempt && !push) err_q <= 1'b1;
      end
   end
   assign ld_be  = be_of(sb.ld_addr_i[1:0], sb.ld_size_i);
   assign ld_bad = bad(sb.ld_addr_i[1:0], sb.ld_size_i);
   // Walk oldest to youngest so the last match seen is the youngest one.
   always_comb begin
      found   = 1'b0;
      overlap = 1'b0;
      yng     = '0;
      idx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if (valid_q[idx] && addr_q[idx] == sb.ld_addr_i[31:2]) begin
            found   = 1'b1;
            yng     = idx;
            overlap = overlap | (|(be_q[idx] & ld_be));
         end
      end
      hit = sb.ld_valid_i & found & ~ld_bad & ((be_q[yng] & ld_be) == ld_be);
   end
   assign sb.ld_hit_o      = hit;
   assign sb.ld_data_o     = hit ? data_q[yng] : '0;
   assign sb.ld_conflict_o = sb.ld_valid_i & ~hit & (ld_bad ? found : overlap);
   assign sb.full_o        = full;
   assign sb.empty_o       = empty;
   assign sb.count_o       = count_q;
   assign sb.err_o         = err_q;
   assign sb.mem_req_o     = ~empty;
   assign sb.mem_addr_o    = empty ? '0 : {addr_q[head_q], 2'b00};
   assign sb.mem_data_o    = empty ? '0 : data_q[head_q];
   assign sb.mem_be_o      = empty ? '0 : be_q[head_q];
endmodule
